sorteio_papeis: RTL and testbench

- Role-assignment stage for the game datapath, directly downstream of the game control unit.
- Latches the game seed on `e_seed_reg` and, on `inicia`, builds a per-player role table with a deterministic 16-bit LFSR-driven Fisher-Yates shuffle.
- Raises `pronto` when the table is stable, and serves role lookups by player index for the night-turn logic.

---
 rtl/sorteio_papeis.sv | 146 ++++++++++++++
 tb/tb_sorteio_papeis.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sorteio_papeis.sv
// Role-assignment stage: fills a per-player role table and shuffles it with an
// LFSR-driven Fisher-Yates pass, then serves role lookups by player index.
module sorteio_papeis #(
  parameter int unsigned N_JOGADORES = 8,
  parameter int unsigned N_LOBOS     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        e_seed_reg,
  input  logic [15:0] seed_in,
  input  logic        inicia,
  input  logic [2:0]  consulta_jogador,
  output logic [1:0]  papel,
  output logic        pronto,
  output logic        ocupado,
  output logic [2:0]  db_estado
);

  localparam logic [2:0] StOcioso   = 3'd0;
  localparam logic [2:0] StPreenche = 3'd1;
  localparam logic [2:0] StSorteia  = 3'd2;
  localparam logic [2:0] StTroca    = 3'd3;
  localparam logic [2:0] StFim      = 3'd4;

  localparam logic [1:0] PapelAldeao  = 2'd0;
  localparam logic [1:0] PapelLobo    = 2'd1;
  localparam logic [1:0] PapelVidente = 2'd2;
  localparam logic [1:0] PapelMedico  = 2'd3;

  localparam logic [15:0] SeedPadrao = 16'hACE1;

  localparam logic [2:0] UltimoIdx  = 3'(N_JOGADORES - 1);
  localparam logic [2:0] IdxVidente = 3'(N_LOBOS);
  localparam logic [2:0] IdxMedico  = 3'(N_LOBOS + 1);
  localparam logic [3:0] NumJog     = 4'(N_JOGADORES);

  logic [2:0]  r_estado;
  logic [15:0] r_lfsr;
  logic [2:0]  r_idx;
  logic [2:0]  r_i;
  logic [2:0]  r_j;
  logic [1:0]  r_tab [8];

  logic [2:0]  w_estado_prox;
  logic        w_aceita_cmd;
  logic        w_carrega_seed;
  logic        w_fb;
  logic [3:0]  w_i_mais1;
  logic [11:0] w_prod;
  logic [2:0]  w_j;
  logic [1:0]  w_papel_inicial;

  // Seed load and start are only honoured while no shuffle is running.
  assign w_aceita_cmd   = (r_estado == StOcioso) || (r_estado == StFim);
  assign w_carrega_seed = e_seed_reg && w_aceita_cmd;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Scaled multiply maps the low LFSR byte into 0..i without a divider.
  assign w_i_mais1 = {1'b0, r_i} + 4'd1;
  assign w_prod    = 12'(r_lfsr[7:0]) * 12'(w_i_mais1);
  assign w_j       = 3'(w_prod >> 8);

  always_comb begin
    w_papel_inicial = PapelAldeao;
    if (r_idx < IdxVidente) begin
      w_papel_inicial = PapelLobo;
    end else if (r_idx == IdxVidente) begin
      w_papel_inicial = PapelVidente;
    end else if (r_idx == IdxMedico) begin
      w_papel_inicial = PapelMedico;
    end
  end

  always_comb begin
    w_estado_prox = r_estado;
    case (r_estado)
      StOcioso, StFim: begin
        if (inicia) w_estado_prox = StPreenche;
      end
      StPreenche: begin
        if (r_idx == UltimoIdx) w_estado_prox = StSorteia;
      end
      StSorteia: w_estado_prox = StTroca;
      StTroca: begin
        w_estado_prox = (r_i == 3'd1) ? StFim : StSorteia;
      end
      default: w_estado_prox = StOcioso;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= StOcioso;
      r_lfsr   <= SeedPadrao;
      r_idx    <= 3'd0;
      r_i      <= 3'd0;
      r_j      <= 3'd0;
      for (int k = 0; k < 8; k++) begin
        r_tab[k] <= PapelAldeao;
      end
    end else begin
      r_estado <= w_estado_prox;

      if (w_carrega_seed) begin
        r_lfsr <= (seed_in == 16'd0) ? SeedPadrao : seed_in;
      end else if (r_estado == StSorteia) begin
        r_lfsr <= {r_lfsr[14:0], w_fb};
      end

      case (r_estado)
        StOcioso, StFim: begin
          if (inicia) r_idx <= 3'd0;
        end
        StPreenche: begin
          r_tab[r_idx] <= w_papel_inicial;
          r_idx        <= r_idx + 3'd1;
          if (r_idx == UltimoIdx) r_i <= UltimoIdx;
        end
        StSorteia: begin
          r_j <= w_j;
        end
        StTroca: begin
          // With j == i both writes carry the same value, leaving the entry intact.
          r_tab[r_i] <= r_tab[r_j];
          r_tab[r_j] <= r_tab[r_i];
          if (r_i != 3'd1) r_i <= r_i - 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    papel = PapelAldeao;
    if ({1'b0, consulta_jogador} < NumJog) begin
      papel = r_tab[consulta_jogador];
    end
  end

  assign pronto    = (r_estado == StFim);
  assign ocupado   = (r_estado == StPreenche) || (r_estado == StSorteia) ||
                     (r_estado == StTroca);
  assign db_estado = r_estado;

endmodule

// File: tb/tb_sorteio_papeis.sv
// Bench for sorteio_papeis: randomized seeds checked against a list-level
// Fisher-Yates reference model and cycle-level timing expectations.
`timescale 1ns/1ps
module tb_sorteio_papeis;

  localparam int N  = 8;
  localparam int NL = 2;

  typedef logic [7:0][1:0] tab_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        e_seed_reg = 1'b0;
  logic [15:0] seed_in = 16'd0;
  logic        inicia = 1'b0;
  logic [2:0]  consulta_jogador = 3'd0;
  logic [1:0]  papel;
  logic        pronto;
  logic        ocupado;
  logic [2:0]  db_estado;

  sorteio_papeis #(
    .N_JOGADORES(N),
    .N_LOBOS    (NL)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .e_seed_reg      (e_seed_reg),
    .seed_in         (seed_in),
    .inicia          (inicia),
    .consulta_jogador(consulta_jogador),
    .papel           (papel),
    .pronto          (pronto),
    .ocupado         (ocupado),
    .db_estado       (db_estado)
  );

  always #10 clock = ~clock;

  int checks = 0;
  int failures = 0;

  logic [2:0] obs_estado [0:40];
  logic       obs_pronto [0:40];
  logic       obs_ocup   [0:40];
  tab_t       obs_tab    [0:40];
  int         pronto_cyc;
  tab_t       tab_ace1;

  function automatic logic [15:0] ref_lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & 16'hB400)};
  endfunction

  // Role list after 'trocas' Fisher-Yates steps, starting from the ordered fill.
  function automatic tab_t ref_tabela(input logic [15:0] seed, input int trocas);
    tab_t        t;
    logic [15:0] l;
    logic [1:0]  tmp;
    int          i;
    int          j;
    l = (seed == 16'd0) ? 16'hACE1 : seed;
    t = '0;
    for (int p = 0; p < N; p++) begin
      if (p < NL)          t[p] = 2'd1;
      else if (p == NL)    t[p] = 2'd2;
      else if (p == NL + 1) t[p] = 2'd3;
      else                 t[p] = 2'd0;
    end
    for (int s = 0; s < trocas; s++) begin
      i = N - 1 - s;
      j = (int'(l[7:0]) * (i + 1)) / 256;
      tmp  = t[i];
      t[i] = t[j];
      t[j] = tmp;
      l = ref_lfsr_next(l);
    end
    return t;
  endfunction

  function automatic int ref_estado(input int c);
    if (c <= N) return 1;
    if (c <= 3 * N - 2) return ((c - N) % 2 == 1) ? 2 : 3;
    return 4;
  endfunction

  function automatic int conta_papel(input tab_t t, input logic [1:0] r);
    int n = 0;
    for (int p = 0; p < N; p++) if (t[p] == r) n++;
    return n;
  endfunction

  task automatic ler_tabela(output tab_t t);
    for (int p = 0; p < 8; p++) begin
      consulta_jogador = 3'(p);
      #1;
      t[p] = papel;
    end
  endtask

  task automatic load_seed(input logic [15:0] s);
    @(negedge clock);
    e_seed_reg = 1'b1;
    seed_in    = s;
    @(negedge clock);
    e_seed_reg = 1'b0;
    seed_in    = 16'd0;
  endtask

  // Starts a shuffle and records 40 cycles of observations; optional disturbances.
  task automatic run_shuffle(input bit com_seed, input logic [15:0] seed,
                             input int pulso_inicia_c, input bit ruido_seed, input int reset_c);
    @(negedge clock);
    inicia     = 1'b1;
    e_seed_reg = com_seed;
    seed_in    = seed;
    @(posedge clock);
    pronto_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      obs_estado[c] = db_estado;
      obs_pronto[c] = pronto;
      obs_ocup[c]   = ocupado;
      ler_tabela(obs_tab[c]);
      if (pronto === 1'b1 && pronto_cyc < 0) pronto_cyc = c;
      inicia     = (c + 1 == pulso_inicia_c);
      e_seed_reg = ruido_seed && (c + 1 >= 2) && (c + 1 <= 20);
      seed_in    = ruido_seed ? (16'($urandom) | 16'd1) : 16'd0;
      reset      = (reset_c != 0) && (c + 1 == reset_c);
    end
    inicia     = 1'b0;
    e_seed_reg = 1'b0;
    seed_in    = 16'd0;
    reset      = 1'b0;
  endtask

  task automatic test_reset();
    tab_t t;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (pronto !== 1'b0) begin
      failures++;
      $display("FAIL reset_pronto got=%b exp=0", pronto);
    end
    checks++;
    if (ocupado !== 1'b0) begin
      failures++;
      $display("FAIL reset_ocupado got=%b exp=0", ocupado);
    end
    checks++;
    if (db_estado !== 3'd0) begin
      failures++;
      $display("FAIL reset_estado got=%0d exp=0", db_estado);
    end
    ler_tabela(t);
    for (int p = 0; p < 8; p++) begin
      checks++;
      if (t[p] !== 2'd0) begin
        failures++;
        $display("FAIL reset_papel[%0d] got=%0d exp=0", p, t[p]);
      end
    end
  endtask

  task automatic test_shuffle_ace1();
    tab_t exp;
    load_seed(16'hACE1);
    run_shuffle(1'b0, 16'd0, 0, 1'b0, 0);
    for (int c = 1; c <= 40; c++) begin
      checks++;
      if (int'(obs_estado[c]) != ref_estado(c)) begin
        failures++;
        $display("FAIL ace1_estado c=%0d got=%0d exp=%0d", c, obs_estado[c], ref_estado(c));
      end
      checks++;
      if (obs_ocup[c] !== (ref_estado(c) <= 3)) begin
        failures++;
        $display("FAIL ace1_ocupado c=%0d got=%b", c, obs_ocup[c]);
      end
    end
    // Table seen in each SORTEIA cycle reflects k completed swaps.
    for (int k = 0; k < N - 1; k++) begin
      exp = ref_tabela(16'hACE1, k);
      checks++;
      if (obs_tab[N + 1 + 2 * k] !== exp) begin
        failures++;
        $display("FAIL ace1_passo k=%0d got=%h exp=%h", k, obs_tab[N + 1 + 2 * k], exp);
      end
    end
    checks++;
    if (pronto_cyc != 3 * N - 1) begin
      failures++;
      $display("FAIL ace1_pronto_ciclo got=%0d exp=%0d", pronto_cyc, 3 * N - 1);
    end
    exp = ref_tabela(16'hACE1, N - 1);
    checks++;
    if (obs_tab[40] !== exp) begin
      failures++;
      $display("FAIL ace1_tabela got=%h exp=%h", obs_tab[40], exp);
    end
    checks++;
    if (conta_papel(obs_tab[40], 2'd1) != NL || conta_papel(obs_tab[40], 2'd2) != 1 ||
        conta_papel(obs_tab[40], 2'd3) != 1 || conta_papel(obs_tab[40], 2'd0) != N - NL - 2) begin
      failures++;
      $display("FAIL ace1_contagem got=%h exp=%0d/1/1/%0d", obs_tab[40], NL, N - NL - 2);
    end
    tab_ace1 = obs_tab[40];
  endtask

  task automatic test_repetibilidade();
    logic [15:0] x;
    tab_t        t1;
    x = 16'($urandom_range(1, 65535));
    load_seed(x);
    run_shuffle(1'b0, 16'd0, 0, 1'b0, 0);
    t1 = obs_tab[40];
    load_seed(x);
    run_shuffle(1'b0, 16'd0, 0, 1'b0, 0);
    checks++;
    if (obs_tab[40] !== t1) begin
      failures++;
      $display("FAIL repete_mesma_seed got=%h exp=%h", obs_tab[40], t1);
    end
    checks++;
    if (t1 !== ref_tabela(x, N - 1)) begin
      failures++;
      $display("FAIL repete_modelo seed=%h got=%h exp=%h", x, t1, ref_tabela(x, N - 1));
    end
    load_seed(16'd0);
    run_shuffle(1'b0, 16'd0, 0, 1'b0, 0);
    checks++;
    if (obs_tab[40] !== tab_ace1) begin
      failures++;
      $display("FAIL seed_zero got=%h exp=%h", obs_tab[40], tab_ace1);
    end
    load_seed(16'h1234);
    run_shuffle(1'b0, 16'd0, 0, 1'b0, 0);
    checks++;
    if (obs_tab[40] === tab_ace1) begin
      failures++;
      $display("FAIL seed_1234_difere got=%h exp!=%h", obs_tab[40], tab_ace1);
    end
    checks++;
    if (obs_tab[40] !== ref_tabela(16'h1234, N - 1)) begin
      failures++;
      $display("FAIL seed_1234_modelo got=%h exp=%h", obs_tab[40], ref_tabela(16'h1234, N - 1));
    end
  endtask

  task automatic test_entradas_ignoradas();
    load_seed(16'hACE1);
    run_shuffle(1'b0, 16'd0, 5, 1'b1, 0);
    checks++;
    if (pronto_cyc != 3 * N - 1) begin
      failures++;
      $display("FAIL ignora_pronto_ciclo got=%0d exp=%0d", pronto_cyc, 3 * N - 1);
    end
    for (int c = 1; c <= 3 * N - 1; c++) begin
      checks++;
      if (int'(obs_estado[c]) != ref_estado(c)) begin
        failures++;
        $display("FAIL ignora_estado c=%0d got=%0d exp=%0d", c, obs_estado[c], ref_estado(c));
      end
    end
    checks++;
    if (obs_tab[40] !== ref_tabela(16'hACE1, N - 1)) begin
      failures++;
      $display("FAIL ignora_tabela got=%h exp=%h", obs_tab[40], ref_tabela(16'hACE1, N - 1));
    end
  endtask

  task automatic test_reset_meio();
    load_seed(16'($urandom_range(1, 65535)));
    run_shuffle(1'b0, 16'd0, 0, 1'b0, 12);
    checks++;
    if (obs_estado[13] !== 3'd0 || obs_pronto[13] !== 1'b0 || obs_ocup[13] !== 1'b0) begin
      failures++;
      $display("FAIL reset_meio_estado got=%0d/%b/%b exp=0/0/0",
               obs_estado[13], obs_pronto[13], obs_ocup[13]);
    end
    checks++;
    if (obs_tab[13] !== '0) begin
      failures++;
      $display("FAIL reset_meio_tabela got=%h exp=0", obs_tab[13]);
    end
    // Reset restores the default seed, so the next shuffle matches the ACE1 table.
    run_shuffle(1'b0, 16'd0, 0, 1'b0, 0);
    checks++;
    if (pronto_cyc != 3 * N - 1) begin
      failures++;
      $display("FAIL reset_meio_pronto got=%0d exp=%0d", pronto_cyc, 3 * N - 1);
    end
    checks++;
    if (obs_tab[40] !== ref_tabela(16'hACE1, N - 1)) begin
      failures++;
      $display("FAIL reset_meio_refaz got=%h exp=%h", obs_tab[40], ref_tabela(16'hACE1, N - 1));
    end
  endtask

  task automatic test_fim_com_seed();
    logic [15:0] s;
    s = 16'($urandom_range(1, 65535));
    run_shuffle(1'b1, s, 0, 1'b0, 0);
    checks++;
    if (obs_pronto[1] !== 1'b0 || obs_estado[1] !== 3'd1) begin
      failures++;
      $display("FAIL fim_seed_queda got=%b/%0d exp=0/1", obs_pronto[1], obs_estado[1]);
    end
    checks++;
    if (pronto_cyc != 3 * N - 1) begin
      failures++;
      $display("FAIL fim_seed_pronto got=%0d exp=%0d", pronto_cyc, 3 * N - 1);
    end
    checks++;
    if (obs_tab[40] !== ref_tabela(s, N - 1)) begin
      failures++;
      $display("FAIL fim_seed_tabela seed=%h got=%h exp=%h", s, obs_tab[40], ref_tabela(s, N - 1));
    end
  endtask

  initial begin
    test_reset();
    test_shuffle_ace1();
    test_repetibilidade();
    test_entradas_ignoradas();
    test_reset_meio();
    test_fim_com_seed();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
